beep_seq_gen: RTL and testbench
===============================

Name: beep_seq_gen

Overview:
- Parametrised successor to the fixed 1 kHz buzzer driver.
- Generates a square tone with a runtime-programmable half-period.
- Tone is gated into a programmable sequence: on-time, off-time and repeat count, all in milliseconds.
- Start/busy/done handshake toward the control logic; drives the board buzzer pin directly.

Parameters:
- CLK_HZ, 48_000_000, input clock frequency in Hz; MS_DIV = CLK_HZ/1000 cycles per ms.
- HP_W, 20, width of the half-period field in clock cycles.
- MS_W, 16, width of the on/off duration fields in ms.
- REP_W, 4, width of the repeat-count field.
- IDLE_Z, 1, 1: beep is high-Z when silent; 0: beep is driven 0 when silent.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  stop the sequence immediately.
- half_period  in  HP_W  tone half-period in cycles; 0 is treated as 1.
- on_ms  in  MS_W  tone-on duration per beep.
- off_ms  in  MS_W  silence between beeps.
- repeats  in  REP_W  number of beeps.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at normal completion.
- beep  out  1  buzzer drive.
- beep_oe  out  1  1 while tone is gated onto beep.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all counters 0; tone=0.
  - busy=0, done=0, beep_oe=0.
  - beep = z if IDLE_Z=1, else 0.
- Config latch: half_period, on_ms, off_ms and repeats are captured on an accepted start. Input changes while busy have no effect.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - start=1 with on_ms!=0 and repeats!=0 -> ON at the next edge.
  - start=1 with on_ms==0 or repeats==0 -> stay IDLE, pulse done next cycle, busy stays 0.
- ON:
  - Entered with tone=1, half-period counter=0 and ms prescaler=0.
  - Tone toggles every max(half_period,1) cycles.
  - beep = tone, beep_oe = 1.
  - Lasts exactly on_ms*MS_DIV cycles.
  - At the end, decrement the remaining-repeat count:
    - if the remaining count becomes 0 -> IDLE and pulse done;
    - otherwise -> OFF, or straight to ON (tone restarts at 1) if off_ms==0.
- OFF:
  - Silent; beep = idle value, beep_oe = 0.
  - Lasts exactly off_ms*MS_DIV cycles, then -> ON.
  - No OFF period follows the last beep.
- busy: 1 in ON and OFF, 0 in IDLE.
- Latency: start sampled at edge N -> busy=1 and beep=1 in cycle N+1.
- done: registered; high for exactly one cycle, in the same cycle busy first reads 0.
- abort:
  - In ON/OFF -> IDLE at the next edge; beep silent, no done pulse.
  - abort and start in the same IDLE cycle: abort wins, start is ignored.
- start while busy: ignored, no queueing.
- Counters:
  - ms prescaler counts 0..MS_DIV-1, wraps, and resets on every state entry.
  - ms counter compares against the latched duration; no wrap beyond MS_W.
  - The half-period counter is HP_W wide.
- Reset mid-sequence: immediate silence and IDLE state; no done pulse.

Decomposition:
- Package beep_pkg:
  - state encoding (IDLE/ON/OFF);
  - function computing MS_DIV from CLK_HZ;
  - default tone constant for 1 kHz at 48 MHz: HP_1K = 24_000.
- One sub-module, ms_tick_gen:
  - parameter MS_DIV; inputs clk, rst_n, clr;
  - output tick, a one-cycle pulse every MS_DIV cycles after clr.
- The top level instantiates ms_tick_gen once and holds the FSM, tone counter and repeat counter.

Test Plan (CLK_HZ=8000, so MS_DIV=8; start pulsed at edge 0):
- Basic sequence: half_period=2, on_ms=2, off_ms=1, repeats=2.
  - Expected: beep toggles 1,1,0,0,… in cycles 1–16; silent in 17–24; toggles again in 25–40.
  - done=1 and busy=0 in cycle 41.
- Clamp and single beep: half_period=0, on_ms=1, repeats=1.
  - Expected: beep alternates every cycle 1,0,1,… for 8 cycles; done in cycle 9.
- Back-to-back beeps: off_ms=0, repeats=3, on_ms=1.
  - Expected: 24 continuous ON cycles with tone restarting at 1 in cycles 1, 9 and 17.
  - beep_oe never drops.
- Abort: abort at cycle 20 of the basic sequence.
  - Expected: IDLE in cycle 21, beep silent, done never asserted.
  - A second start during busy has no effect.
- Degenerate start: repeats=0 -> busy stays 0, done=1 in cycle 1, beep never driven.
- Reset and idle drive: rst_n low mid-ON.
  - Expected: beep = z immediately with IDLE_Z=1; rerun with IDLE_Z=0 and check beep=0.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared types and constants for the programmable beep sequencer.
package beep_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } beep_state_e;

  // Default half-period for a 1 kHz tone from a 48 MHz clock
  localparam int unsigned HP_1K = 24_000;

  // Clock cycles per millisecond
  function automatic int unsigned ms_div(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/beep_seq_gen_if.sv
// Control handshake and sequence configuration for the beep sequencer.
interface beep_seq_gen_if #(
  parameter int unsigned HP_W  = 20,
  parameter int unsigned MS_W  = 16,
  parameter int unsigned REP_W = 4
);
  logic             start;
  logic             abort;
  logic [HP_W-1:0]  half_period;
  logic [MS_W-1:0]  on_ms;
  logic [MS_W-1:0]  off_ms;
  logic [REP_W-1:0] repeats;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, half_period, on_ms, off_ms, repeats,
    input  busy, done
  );

  modport slave (
    input  start, abort, half_period, on_ms, off_ms, repeats,
    output busy, done
  );
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: tick is high in every MS_DIV-th cycle after clr.
module ms_tick_gen #(
  parameter int unsigned MS_DIV = 48_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next prescaler count; tick is registered so it lines up with cnt == LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Prescaler registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/beep_seq_gen.sv
// Programmable beep sequencer: gated square tone with on/off/repeat timing.
module beep_seq_gen
  import beep_pkg::*;
#(
  parameter int unsigned CLK_HZ = 48_000_000,
  parameter int unsigned HP_W   = 20,
  parameter int unsigned MS_W   = 16,
  parameter int unsigned REP_W  = 4,
  parameter int unsigned IDLE_Z = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  beep_seq_gen_if.slave   ctl,
  output wire             beep,
  output logic            beep_oe
);
  localparam int unsigned MS_DIV = ms_div(CLK_HZ);

  beep_state_e      state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [HP_W-1:0]  hp_cnt_q, hp_cnt_d;
  logic [MS_W-1:0]  on_q, on_d;
  logic [MS_W-1:0]  off_q, off_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             oe_q, oe_d;
  logic             clr_c;
  logic             tick;

  ms_tick_gen #(.MS_DIV(MS_DIV)) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_c),
    .tick  (tick)
  );

  // Next-state, counters and config latch
  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    hp_cnt_d = hp_cnt_q;
    on_d     = on_q;
    off_d    = off_q;
    ms_cnt_d = ms_cnt_q;
    rep_d    = rep_q;
    tone_d   = tone_q;
    done_d   = 1'b0;
    clr_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clr_c    = 1'b1;
        tone_d   = 1'b0;
        hp_cnt_d = '0;
        ms_cnt_d = '0;
        if (ctl.start && !ctl.abort) begin
          if (ctl.on_ms != '0 && ctl.repeats != '0) begin
            state_d = ST_ON;
            hp_d    = (ctl.half_period == '0) ? HP_W'(1) : ctl.half_period;
            on_d    = ctl.on_ms;
            off_d   = ctl.off_ms;
            rep_d   = ctl.repeats;
            tone_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_ON: begin
        if (ctl.abort) begin
          state_d = ST_IDLE;
          tone_d  = 1'b0;
        end else begin
          if (hp_cnt_q == hp_q - HP_W'(1)) begin
            tone_d   = ~tone_q;
            hp_cnt_d = '0;
          end else begin
            hp_cnt_d = hp_cnt_q + HP_W'(1);
          end
          if (tick) begin
            if (ms_cnt_q == on_q - MS_W'(1)) begin
              ms_cnt_d = '0;
              rep_d    = rep_q - REP_W'(1);
              clr_c    = 1'b1;
              hp_cnt_d = '0;
              if (rep_q == REP_W'(1)) begin
                state_d = ST_IDLE;
                tone_d  = 1'b0;
                done_d  = 1'b1;
              end else if (off_q == '0) begin
                tone_d = 1'b1;
              end else begin
                state_d = ST_OFF;
                tone_d  = 1'b0;
              end
            end else begin
              ms_cnt_d = ms_cnt_q + MS_W'(1);
            end
          end
        end
      end

      ST_OFF: begin
        if (ctl.abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (ms_cnt_q == off_q - MS_W'(1)) begin
            state_d  = ST_ON;
            ms_cnt_d = '0;
            hp_cnt_d = '0;
            tone_d   = 1'b1;
            clr_c    = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tone_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    oe_d   = (state_d == ST_ON);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hp_q     <= '0;
      hp_cnt_q <= '0;
      on_q     <= '0;
      off_q    <= '0;
      ms_cnt_q <= '0;
      rep_q    <= '0;
      tone_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      hp_cnt_q <= hp_cnt_d;
      on_q     <= on_d;
      off_q    <= off_d;
      ms_cnt_q <= ms_cnt_d;
      rep_q    <= rep_d;
      tone_q   <= tone_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      oe_q     <= oe_d;
    end
  end

  assign ctl.busy = busy_q;
  assign ctl.done = done_q;
  assign beep_oe  = oe_q;
  // Pin drive: tone while gated, otherwise release or pull low
  assign beep = oe_q ? tone_q : ((IDLE_Z != 0) ? 1'bz : 1'b0);

endmodule

// File: tb/tb_beep_seq_gen.sv
// Scoreboard bench for beep_seq_gen at CLK_HZ=8000 (8 cycles per ms).
module tb_beep_seq_gen;
  localparam int unsigned CLK_HZ = 8000;

  typedef struct packed {
    logic busy;
    logic done;
    logic oe;
    logic tone;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beep_seq_gen_if if0 ();
  beep_seq_gen_if if1 ();
  wire  beep0, beep1;
  logic oe0, oe1;

  beep_seq_gen #(.CLK_HZ(CLK_HZ), .IDLE_Z(1)) dut (
    .clk(clk), .rst_n(rst_n), .ctl(if0), .beep(beep0), .beep_oe(oe0)
  );

  beep_seq_gen #(.CLK_HZ(CLK_HZ), .IDLE_Z(0)) dut_z0 (
    .clk(clk), .rst_n(rst_n), .ctl(if1), .beep(beep1), .beep_oe(oe1)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_n  = 0;

  // Monitor: one expected entry per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic bad;
      e = exp_q.pop_front();
      checks++;
      bad = (if0.busy !== e.busy) || (if0.done !== e.done) || (oe0 !== e.oe) ||
            (e.oe && (beep0 !== e.tone)) ||
            (if1.busy !== e.busy) || (if1.done !== e.done) || (oe1 !== e.oe) ||
            (beep1 !== (e.oe ? e.tone : 1'b0));
      if (bad) begin
        errors++;
        $display("FAIL seq[%0d] got busy=%b done=%b oe=%b beep=%b beep_z0=%b, expected busy=%b done=%b oe=%b tone=%b",
                 mon_n, if0.busy, if0.done, oe0, beep0, beep1, e.busy, e.done, e.oe, e.tone);
      end
      mon_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input int hp, input int on, input int off, input int rep);
    if0.half_period = 20'(hp); if1.half_period = 20'(hp);
    if0.on_ms       = 16'(on); if1.on_ms       = 16'(on);
    if0.off_ms      = 16'(off); if1.off_ms     = 16'(off);
    if0.repeats     = 4'(rep); if1.repeats     = 4'(rep);
  endtask

  task automatic ctl(input logic s, input logic a);
    if0.start = s; if1.start = s;
    if0.abort = a; if1.abort = a;
  endtask

  task automatic push(input logic b, input logic d, input logic o, input logic t);
    exp_t e;
    e.busy = b; e.done = d; e.oe = o; e.tone = t;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_off(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Tone starts high and toggles every max(h,1) cycles
  task automatic push_on(input int n, input int h);
    int hh;
    hh = (h == 0) ? 1 : h;
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b1, ((i / hh) % 2) == 0);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 500;
    while (exp_q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain: %0d entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg(0, 0, 0, 0);
    ctl(1'b0, 1'b0);

    // Reset state
    step();
    push_idle(2);
    step(); step();
    rst_n = 1'b1;
    drain("reset");

    // Basic sequence: 2 beeps of 2 ms, 1 ms gap, half-period 2
    step();
    cfg(2, 2, 1, 2);
    ctl(1'b1, 1'b0);
    push_idle(1);
    push_on(16, 2);
    push_off(8);
    push_on(16, 2);
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push_idle(2);
    step();
    ctl(1'b0, 1'b0);
    drain("basic");

    // Half-period 0 clamps to 1; single 1 ms beep
    step();
    cfg(0, 1, 3, 1);
    ctl(1'b1, 1'b0);
    push_idle(1);
    push_on(8, 1);
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push_idle(2);
    step();
    ctl(1'b0, 1'b0);
    drain("clamp");

    // Back-to-back beeps: tone restarts high at each beep
    step();
    cfg(3, 1, 0, 3);
    ctl(1'b1, 1'b0);
    push_idle(1);
    push_on(8, 3);
    push_on(8, 3);
    push_on(8, 3);
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push_idle(2);
    step();
    ctl(1'b0, 1'b0);
    drain("b2b");

    // Abort during OFF; restart attempt and config change while busy ignored
    step();
    cfg(2, 2, 1, 2);
    ctl(1'b1, 1'b0);
    push_idle(1);
    push_on(16, 2);
    push_off(4);
    push_idle(6);
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 1) ctl(1'b0, 1'b0);
      if (k == 5) begin cfg(1, 1, 0, 1); ctl(1'b1, 1'b0); end
      if (k == 6) ctl(1'b0, 1'b0);
      if (k == 20) ctl(1'b0, 1'b1);
      if (k == 21) ctl(1'b0, 1'b0);
    end
    drain("abort");

    // Degenerate start: repeats 0 gives done only
    step();
    cfg(2, 1, 1, 0);
    ctl(1'b1, 1'b0);
    push_idle(1);
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push_idle(2);
    step();
    ctl(1'b0, 1'b0);
    drain("degenerate");

    // Start together with abort in IDLE is ignored
    step();
    cfg(2, 1, 1, 1);
    ctl(1'b1, 1'b1);
    push_idle(4);
    step();
    ctl(1'b0, 1'b0);
    drain("start_abort");

    // Reset mid-ON: immediate silence, no done afterwards
    step();
    cfg(2, 2, 1, 2);
    ctl(1'b1, 1'b0);
    push_idle(1);
    push_on(5, 2);
    push_idle(5);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) ctl(1'b0, 1'b0);
      if (k == 6) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (oe0 !== 1'b0 || beep0 === 1'b1 || if0.busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_async_z got oe=%b beep=%b busy=%b, expected oe=0 beep released busy=0",
                   oe0, beep0, if0.busy);
        end
        checks++;
        if (beep1 !== 1'b0 || oe1 !== 1'b0) begin
          errors++;
          $display("FAIL reset_async_drive0 got beep=%b oe=%b, expected beep=0 oe=0", beep1, oe1);
        end
      end
      if (k == 8) rst_n = 1'b1;
    end
    drain("reset_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
